// File: rtl/ripple_sync.sv
// Synchronizes an asynchronous ripple counter, filters transient codes and reports settled counts over valid/ready.
// Optional feature: define RIPPLE_SYNC_WRAP_CNT_EN to add the 8-bit wrapCount output.
module ripple_sync #(
  parameter int WIDTH  = 4,
  parameter int STABLE = 2
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic [WIDTH-1:0] countIn,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  input  logic             ready,
  output logic             step,
  output logic             wrap,
  output logic             overrun
`ifdef RIPPLE_SYNC_WRAP_CNT_EN
  ,
  output logic [7:0]       wrapCount
`endif
);

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  // Handshake: value is offered while valid=1; it is consumed at a rising edge with valid=1 and ready=1.
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [3:0]       r_run;
  logic [WIDTH-1:0] r_settled;
  logic [WIDTH-1:0] r_value;
  logic             r_valid;
  logic             r_step;
  logic             r_wrap;
  logic             r_overrun;

  logic             w_chg;
  logic [3:0]       w_run_nxt;
  logic             w_accept;
  logic             w_step;
  logic             w_wrap;

  // r_s1 is what r_s2 takes at this edge, so a change is visible before it lands.
  always_comb begin
    w_chg     = (r_s1 != r_s2);
    w_run_nxt = r_run;
    if (w_chg) begin
      w_run_nxt = 4'd1;
    end else if (r_run != STABLE_C) begin
      w_run_nxt = r_run + 4'd1;
    end
    w_accept = (w_run_nxt == STABLE_C) && (w_chg || (r_run != STABLE_C));
    w_step   = w_accept && (r_s1 != r_settled);
    w_wrap   = w_step && (r_settled == {WIDTH{1'b1}}) && (r_s1 == '0);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_run     <= '0;
      r_settled <= '0;
      r_value   <= '0;
      r_valid   <= 1'b0;
      r_step    <= 1'b0;
      r_wrap    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_s1      <= countIn;
      r_s2      <= r_s1;
      r_run     <= w_run_nxt;
      r_step    <= w_step;
      r_wrap    <= w_wrap;
      r_overrun <= w_step && r_valid && !ready;
      if (w_step) begin
        r_settled <= r_s1;
        r_value   <= r_s1;
        r_valid   <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid   <= 1'b0;
      end
    end
  end

`ifdef RIPPLE_SYNC_WRAP_CNT_EN
  logic [7:0] r_wrap_cnt;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_wrap_cnt <= '0;
    end else if (w_wrap) begin
      r_wrap_cnt <= r_wrap_cnt + 8'd1;
    end
  end

  assign wrapCount = r_wrap_cnt;
`endif

  assign value   = r_value;
  assign valid   = r_valid;
  assign step    = r_step;
  assign wrap    = r_wrap;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_ripple_sync.sv
// Bench for ripple_sync: scenario tasks with inline checks and a step-driven scoreboard of expected settled values.
module tb_ripple_sync;

  localparam int WIDTH  = 4;
  localparam int STABLE = 2;

  logic             clock = 1'b0;
  logic             reset_ = 1'b0;
  logic [WIDTH-1:0] countIn = '0;
  logic             ready = 1'b1;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic             step;
  logic             wrap;
  logic             overrun;
`ifdef RIPPLE_SYNC_WRAP_CNT_EN
  logic [7:0]       wrapCount;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_settled = '0;

  ripple_sync #(.WIDTH(WIDTH), .STABLE(STABLE)) dut (
    .clock   (clock),
    .reset_  (reset_),
    .countIn (countIn),
    .value   (value),
    .valid   (valid),
    .ready   (ready),
    .step    (step),
    .wrap    (wrap),
    .overrun (overrun)
`ifdef RIPPLE_SYNC_WRAP_CNT_EN
    ,
    .wrapCount (wrapCount)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_  = 1'b0;
    countIn = '0;
    tick();
    tick();
    reset_    = 1'b1;
    m_settled = '0;
    exp_q.delete();
  endtask

  // scoreboard: every step must match the oldest expected settled value
  always @(posedge clock) begin
    #1;
    if (reset_ && step === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected_step: value=%0d, no step expected", value);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (value !== e) begin
          tests_failed++;
          $display("FAIL sb_value: got %0d want %0d", value, e);
        end
      end
    end
  end

  // drivers
  task automatic wait_step(input string name, output bit got);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (step === 1'b1) got = 1'b1;
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL %s_timeout: no step within 8 cycles", name);
    end
  endtask

  // Drives a steady count and returns just after the resulting step edge.
  task automatic settle_to(input logic [WIDTH-1:0] v, input string name);
    bit got;
    countIn = v;
    if (v != m_settled) begin
      exp_q.push_back(v);
      m_settled = v;
      wait_step(name, got);
    end else begin
      for (int i = 0; i < 5; i++) tick();
    end
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    #1;
    tests_run++;
    if ({value, valid, step, wrap, overrun} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got value=%0d valid=%0b step=%0b wrap=%0b overrun=%0b want all 0",
               value, valid, step, wrap, overrun);
    end
`ifdef RIPPLE_SYNC_WRAP_CNT_EN
    tests_run++;
    if (wrapCount !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_wrapcount: got %0d want 0", wrapCount);
    end
`endif
    do_reset();
    begin
      int steps = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (step === 1'b1) steps++;
      end
      tests_run++;
      if (steps != 0 || valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_zero_settle: got steps=%0d valid=%0b want 0 0", steps, valid);
      end
    end
  endtask

  task automatic test_settle();
    logic [2:0] seen;
    do_reset();
    tick();
    countIn = 4'd5;
    exp_q.push_back(4'd5);
    m_settled = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen[i] = step;
    end
    tests_run++;
    if (seen !== 3'b100) begin
      tests_failed++;
      $display("FAIL settle_latency: got step per edge (3..1)=%b want 100", seen);
    end
    tests_run++;
    if (value !== 4'd5 || valid !== 1'b1 || wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL settle_outputs: got value=%0d valid=%0b wrap=%0b want 5 1 0", value, valid, wrap);
    end
    tick();
    tests_run++;
    if (step !== 1'b0) begin
      tests_failed++;
      $display("FAIL settle_pulse_width: got step=%0b want 0", step);
    end
  endtask

  task automatic test_ripple();
    int steps = 0;
    do_reset();
    settle_to(4'd7, "ripple_init");
    tick();
    countIn = 4'd6;
    tick();
    countIn = 4'd4;
    tick();
    countIn = 4'd8;
    exp_q.push_back(4'd8);
    m_settled = 4'd8;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (step === 1'b1) steps++;
    end
    tests_run++;
    if (steps != 1 || value !== 4'd8) begin
      tests_failed++;
      $display("FAIL ripple_filter: got steps=%0d value=%0d want 1 8", steps, value);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    settle_to(4'd15, "wrap_init");
    tests_run++;
    if (wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_on_increase: got wrap=%0b want 0", wrap);
    end
    tick();
    settle_to(4'd0, "wrap");
    tests_run++;
    if (step !== 1'b1 || wrap !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_pulse: got step=%0b wrap=%0b want 1 1", step, wrap);
    end
`ifdef RIPPLE_SYNC_WRAP_CNT_EN
    tests_run++;
    if (wrapCount !== 8'd1) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d want 1", wrapCount);
    end
`endif
    tick();
    tests_run++;
    if (wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_pulse_width: got wrap=%0b want 0", wrap);
    end
    settle_to(4'd15, "wrap_up");
    tick();
    settle_to(4'd3, "wrap_decrease");
    tests_run++;
    if (wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_on_decrease: got wrap=%0b want 0", wrap);
    end
  endtask

  task automatic test_handshake();
    do_reset();
    ready = 1'b0;
    settle_to(4'd3, "hs_first");
    tests_run++;
    if (valid !== 1'b1 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL hs_first: got valid=%0b overrun=%0b want 1 0", valid, overrun);
    end
    tick();
    settle_to(4'd4, "hs_second");
    tests_run++;
    if (overrun !== 1'b1 || value !== 4'd4 || valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL hs_overrun: got overrun=%0b value=%0d valid=%0b want 1 4 1", overrun, value, valid);
    end
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (overrun !== 1'b0 || value !== 4'd4 || valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL hs_hold: got overrun=%0b value=%0d valid=%0b want 0 4 1", overrun, value, valid);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || value !== 4'd4) begin
      tests_failed++;
      $display("FAIL hs_consume: got valid=%0b value=%0d want 0 4", valid, value);
    end
    ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready = 1'b0;
    settle_to(4'd2, "b2b_init");
    tick();
    countIn = 4'd9;
    exp_q.push_back(4'd9);
    m_settled = 4'd9;
    tick();
    tick();
    ready = 1'b1;
    tick();
    tests_run++;
    if (step !== 1'b1 || value !== 4'd9 || valid !== 1'b1 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_simultaneous: got step=%0b value=%0d valid=%0b overrun=%0b want 1 9 1 0",
               step, value, valid, overrun);
    end
    tick();
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_consume: got valid=%0b want 0", valid);
    end
  endtask

  task automatic test_reset_mid();
    int steps = 0;
    do_reset();
    ready = 1'b0;
    settle_to(4'd6, "mid_init");
    tick();
    countIn = 4'd11;
    tick();
    reset_ = 1'b0;
    #1;
    tests_run++;
    if ({value, valid, step, wrap, overrun} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got value=%0d valid=%0b step=%0b wrap=%0b overrun=%0b want all 0",
               value, valid, step, wrap, overrun);
    end
    countIn = '0;
    #2;
    reset_    = 1'b1;
    m_settled = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (step === 1'b1) steps++;
    end
    tests_run++;
    if (steps != 0 || valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_resume: got steps=%0d valid=%0b want 0 0", steps, valid);
    end
    ready = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 10; n++) begin
      logic [WIDTH-1:0] v;
      v = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      settle_to(v, "rand");
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_ripple();
    test_wrap();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_random();
    tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: got %0d pending expected values want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
